flash_read_responder: RTL and testbench
=======================================

Name: flash_read_responder

Overview:
- Avalon-MM read-slave responder: the target side of the flash read interface used by the audio playback path.
- Accepts word reads from a master. Read and address are held by the master while waitrequest is high.
- Inserts configurable wait states, fetches 32-bit words from a synchronous ROM/flash-image port, and returns them in order with readdatavalid.
- Used as the flash stand-in behind the playback FSM, in simulation and on-board.

Parameters:
- ADDR_W, 23, word address width.
- DATA_W, 32, read data width.
- WAIT_STATES, 2, extra waitrequest-high cycles before each accept (0..15).
- ROM_LATENCY, 1, cycles from rom_rden to valid rom_q (1..4).
- RESP_DEPTH, 4, response FIFO entries; also the maximum number of outstanding reads.
- MAX_ADDR, 23'h0FFFFF, highest legal word address.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- avs_read  in  1  read request, held until accepted
- avs_address  in  ADDR_W  word address
- avs_waitrequest  out  1  high = request not accepted this cycle
- avs_readdata  out  DATA_W  response data
- avs_readdatavalid  out  1  one-cycle strobe per response
- rom_address  out  ADDR_W  ROM address
- rom_rden  out  1  ROM read enable, one cycle per accepted read
- rom_q  in  DATA_W  ROM data, valid ROM_LATENCY cycles after rom_rden
- busy  out  1  high while any read is waiting, in flight or queued

Behaviour:
- Interface: one clock, clk. Reset is reset_n, asynchronous, active-low.
- Reset values: state=IDLE, wait counter=0, in-flight pipe cleared, FIFO empty, avs_readdatavalid=0, avs_readdata=0, rom_rden=0, rom_address=0, busy=0.
- avs_waitrequest is combinational and is 1 except in ACCEPT when space is available.
- States:
  - IDLE: if avs_read=1, load wait counter with WAIT_STATES. Go to WAIT, or straight to ACCEPT if WAIT_STATES=0.
  - WAIT: decrement the counter each cycle. At 0, go to ACCEPT. If avs_read drops, return to IDLE with no response.
  - ACCEPT: space = (fifo_count + inflight) < RESP_DEPTH.
    - If avs_read=1 and space: waitrequest=0, rom_address=avs_address, rom_rden=1 (same cycle), push a token into the ROM_LATENCY-deep valid shift pipe, then go to IDLE.
    - If no space: stay in ACCEPT with waitrequest=1.
    - If avs_read=0: go to IDLE.
- Address is sampled only in the accept cycle. Changes during WAIT are legal.
- When the token exits the pipe, push rom_q into the FIFO at that clock edge.
- FIFO pop: whenever non-empty, one entry per cycle. avs_readdata/avs_readdatavalid are registered from the pop. There is no back-pressure on responses.
- Latency, request first seen in IDLE at cycle T:
  - accept at T+WAIT_STATES+1
  - readdatavalid at T+WAIT_STATES+ROM_LATENCY+2
  - default parameters: T+5
- Minimum spacing between accepts is 2 cycles (IDLE then ACCEPT).
- Simultaneous FIFO push and pop keeps the count unchanged. The FIFO never overflows because inflight is included in the space check.
- Responses are strictly in accept order.
- busy = (state≠IDLE) | (inflight≠0) | (fifo_count≠0).
- Reset mid-operation: in-flight and queued responses are discarded and no readdatavalid is emitted afterwards.

Optional Feature:
- Macro: FLASH_RESP_ADDR_CHECK_EN.
- Defined:
  - An accepted address > MAX_ADDR does not assert rom_rden.
  - A bypass token still traverses the valid pipe, so latency and ordering are unchanged.
  - The response data is 32'hDEAD_BEEF.
- Undefined: the address is masked to ADDR_W and passed to the ROM unchecked.

Decomposition:
- Package flash_resp_pkg holds:
  - the state enum (IDLE, WAIT, ACCEPT)
  - the default widths
  - the error pattern constant 32'hDEAD_BEEF
- Sub-module flash_resp_fifo: synchronous FIFO with DATA_W/RESP_DEPTH parameters and push, pop, count, empty ports.

Test Plan:
- Single read addr 23'h000010, ROM word 32'h11223344, defaults -> waitrequest low exactly at T+3; rom_rden one cycle with rom_address=23'h000010; readdatavalid one cycle at T+5 with 32'h11223344.
- WAIT_STATES=0, ROM_LATENCY=3, master issuing back-to-back reads 0,1,2,3 -> accepts every 2 cycles; four in-order responses with data=ROM[0..3]; busy drops one cycle after the last valid.
- RESP_DEPTH=2, ROM_LATENCY=4, continuous reads -> third accept stalls in ACCEPT with waitrequest=1 until the first response pops; no data lost.
- avs_read dropped during WAIT (addr 23'h000020) -> return to IDLE, no rom_rden, no readdatavalid.
- reset_n pulsed low while two reads are queued -> outputs at reset values immediately; no readdatavalid after release.
- With FLASH_RESP_ADDR_CHECK_EN, read 23'h100000 -> no rom_rden, readdatavalid at T+5 with 32'hDEAD_BEEF. Without the macro, rom_address=23'h100000.

Source files
------------

// File: rtl/flash_read_responder_pkg.sv
// flash_resp_pkg: shared state encoding, default widths and error word for flash_read_responder
package flash_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCEPT} state_t;
  localparam int ADDR_W_DEF = 23;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
endpackage

// File: rtl/flash_read_responder_if.sv
// flash_read_responder_if: Avalon-MM read channel between playback master and flash responder
interface flash_read_responder_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              avs_read;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;
  modport master (output avs_read, avs_address, input avs_waitrequest, avs_readdata, avs_readdatavalid);
  modport slave (input avs_read, avs_address, output avs_waitrequest, avs_readdata, avs_readdatavalid);
endinterface

// File: rtl/flash_read_responder_fifo.sv
// flash_resp_fifo: first-word-fall-through response FIFO; a push into an empty FIFO can be popped the same cycle
module flash_resp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              empty
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wp_d = push ? (wp_q == AW'(DEPTH - 1) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d = pop ? (rp_q == AW'(DEPTH - 1) ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = empty ? din : mem_q[rp_q];
endmodule

// File: rtl/flash_read_responder.sv
// flash_read_responder: Avalon-MM read slave with wait states, ROM fetch pipe and in-order responses.
// Define FLASH_RESP_ADDR_CHECK_EN to answer addresses above MAX_ADDR with ERR_WORD instead of reading the ROM.
module flash_read_responder
  import flash_resp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WAIT_STATES = 2,
  parameter int ROM_LATENCY = 1,
  parameter int RESP_DEPTH = 4,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(23'h0FFFFF)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  flash_read_responder_if.slave avs,
  output logic [ADDR_W-1:0]     rom_address,
  output logic                  rom_rden,
  input  logic [DATA_W-1:0]     rom_q,
  output logic                  busy
);
`ifdef FLASH_RESP_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int CW = $clog2(RESP_DEPTH + 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ROM_LATENCY-1:0] pipe_q, pipe_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, word, fifo_dout;
  logic rvalid_q, rvalid_d, busy_q, busy_d;
  logic accept, space, bad, exit_tok, pop, empty;
  logic [CW-1:0] fifo_cnt;
  flash_resp_fifo #(.DATA_W(DATA_W), .DEPTH(RESP_DEPTH)) u_fifo (
    .clk, .reset_n, .push(exit_tok), .din(word), .pop, .dout(fifo_dout), .count(fifo_cnt), .empty
  );
  // Tokens still in the ROM pipe reserve a FIFO slot, so the FIFO can never overflow.
  always_comb begin
    space = int'(fifo_cnt) + $countones(pipe_q) < RESP_DEPTH;
    accept = state_q == ACCEPT && avs.avs_read && space;
    bad = CHK && avs.avs_address > MAX_ADDR;
    avs.avs_waitrequest = !accept;
    rom_rden = accept && !bad;
    rom_address = accept ? avs.avs_address : '0;
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && avs.avs_read) begin
      state_d = WAIT_STATES == 0 ? ACCEPT : WAIT;
      cnt_d = 4'(WAIT_STATES);
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = !avs.avs_read ? IDLE : cnt_q <= 4'd1 ? ACCEPT : WAIT;
    end else if (state_q == ACCEPT && (!avs.avs_read || space)) begin
      state_d = IDLE;
    end
    pipe_d = ROM_LATENCY'({pipe_q, accept});
    err_d = ROM_LATENCY'({err_q, accept && bad});
    exit_tok = pipe_q[ROM_LATENCY-1];
    word = err_q[ROM_LATENCY-1] ? DATA_W'(ERR_WORD) : rom_q;
    pop = !empty || exit_tok;
    rvalid_d = pop;
    rdata_d = pop ? fifo_dout : rdata_q;
    busy_d = state_q != IDLE || |pipe_q || !empty;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pipe_q <= '0;
      err_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pipe_q <= pipe_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      busy_q <= busy_d;
    end
  end
  assign avs.avs_readdata = rdata_q;
  assign avs.avs_readdatavalid = rvalid_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_flash_read_responder.sv
// tb_flash_read_responder: three parameterisations driven by a bench master, checked against a ROM model and scoreboard
module tb_flash_read_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int errors = 0;
  logic rd [3];
  logic [22:0] ad [3];
  logic wr [3];
  logic rv [3];
  logic [31:0] rdat [3];
  logic rdn [3];
  logic [22:0] ra [3];
  logic [31:0] rq [3];
  logic bsy [3];
  flash_read_responder_if i0 ();
  flash_read_responder_if i1 ();
  flash_read_responder_if i2 ();
  assign i0.avs_read = rd[0];
  assign i0.avs_address = ad[0];
  assign i1.avs_read = rd[1];
  assign i1.avs_address = ad[1];
  assign i2.avs_read = rd[2];
  assign i2.avs_address = ad[2];
  assign wr[0] = i0.avs_waitrequest;
  assign wr[1] = i1.avs_waitrequest;
  assign wr[2] = i2.avs_waitrequest;
  assign rv[0] = i0.avs_readdatavalid;
  assign rv[1] = i1.avs_readdatavalid;
  assign rv[2] = i2.avs_readdatavalid;
  assign rdat[0] = i0.avs_readdata;
  assign rdat[1] = i1.avs_readdata;
  assign rdat[2] = i2.avs_readdata;
  flash_read_responder u0 (
    .clk(clk), .reset_n(reset_n), .avs(i0.slave), .rom_address(ra[0]), .rom_rden(rdn[0]), .rom_q(rq[0]), .busy(bsy[0])
  );
  flash_read_responder #(.WAIT_STATES(0), .ROM_LATENCY(3)) u1 (
    .clk(clk), .reset_n(reset_n), .avs(i1.slave), .rom_address(ra[1]), .rom_rden(rdn[1]), .rom_q(rq[1]), .busy(bsy[1])
  );
  flash_read_responder #(.WAIT_STATES(0), .ROM_LATENCY(4), .RESP_DEPTH(2)) u2 (
    .clk(clk), .reset_n(reset_n), .avs(i2.slave), .rom_address(ra[2]), .rom_rden(rdn[2]), .rom_q(rq[2]), .busy(bsy[2])
  );
  function automatic logic [31:0] rom_word(input logic [22:0] a);
    return a == 23'h10 ? 32'h11223344 : {9'h0A5, a} ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] expect_word(input logic [22:0] a);
`ifdef FLASH_RESP_ADDR_CHECK_EN
    return a > 23'h0FFFFF ? 32'hDEAD_BEEF : rom_word(a);
`else
    return rom_word(a);
`endif
  endfunction
  // synchronous ROM models: data appears ROM_LATENCY cycles after the address
  logic [22:0] p0 [1];
  logic [22:0] p1 [3];
  logic [22:0] p2 [4];
  always @(posedge clk) begin
    p0[0] <= ra[0];
    p1[0] <= ra[1];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
    p2[0] <= ra[2];
    p2[1] <= p2[0];
    p2[2] <= p2[1];
    p2[3] <= p2[2];
  end
  assign rq[0] = rom_word(p0[0]);
  assign rq[1] = rom_word(p1[2]);
  assign rq[2] = rom_word(p2[3]);
  int acc_c [3][$];
  logic [31:0] exp_d [3][$];
  logic [31:0] obs_d [3][$];
  int obs_c [3][$];
  int rdn_c [3][$];
  logic [22:0] rdn_a [3][$];
  logic busy_log [3][4096];
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd[k] && !wr[k]) begin
        acc_c[k].push_back(cyc);
        exp_d[k].push_back(expect_word(ad[k]));
      end
      if (rv[k]) begin
        obs_d[k].push_back(rdat[k]);
        obs_c[k].push_back(cyc);
      end
      if (rdn[k]) begin
        rdn_c[k].push_back(cyc);
        rdn_a[k].push_back(ra[k]);
      end
      busy_log[k][cyc % 4096] = bsy[k];
    end
  end
  task automatic rd_req(input int k, input logic [22:0] a);
    int n = 0;
    rd[k] = 1'b1;
    ad[k] = a;
    @(negedge clk);
    while (wr[k] && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (wr[k]) begin
      errors++;
      $display("FAIL accept_timeout[%0d]: waitrequest still %0b after %0d cycles, need 0", k, wr[k], n);
    end
    @(posedge clk);
    #1;
    rd[k] = 1'b0;
  endtask
  task automatic wait_obs(input int k, input int n);
    int w = 0;
    while (obs_d[k].size() < n && w < 300) begin
      @(posedge clk);
      w++;
    end
    #1;
    checks++;
    if (obs_d[k].size() < n) begin
      errors++;
      $display("FAIL resp_timeout[%0d]: %0d responses, need %0d", k, obs_d[k].size(), n);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({rv[k], rdat[k], rdn[k], ra[k], bsy[k], wr[k]} !== {1'b0, 32'h0, 1'b0, 23'h0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL reset_vals[%0d]: got rv=%0b rd=%h rden=%0b ra=%h busy=%0b wr=%0b, need 0/0/0/0/0/1",
                 k, rv[k], rdat[k], rdn[k], ra[k], bsy[k], wr[k]);
      end
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic test_single();
    int t, b, ob, rb;
    b = acc_c[0].size();
    ob = obs_d[0].size();
    rb = rdn_c[0].size();
    t = cyc;
    rd_req(0, 23'h000010);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (acc_c[0].size() != b + 1) begin
      errors++;
      $display("FAIL single_acc_count: %0d accepts, need 1", acc_c[0].size() - b);
    end else begin
      checks++;
      if (acc_c[0][b] !== t + 3) begin
        errors++;
        $display("FAIL single_acc_cycle: T+%0d, need T+3", acc_c[0][b] - t);
      end
    end
    checks++;
    if (rdn_c[0].size() != rb + 1) begin
      errors++;
      $display("FAIL single_rden_count: %0d, need 1", rdn_c[0].size() - rb);
    end else begin
      checks++;
      if (rdn_c[0][rb] !== t + 3 || rdn_a[0][rb] !== 23'h000010) begin
        errors++;
        $display("FAIL single_rden: T+%0d addr %h, need T+3 addr 000010", rdn_c[0][rb] - t, rdn_a[0][rb]);
      end
    end
    checks++;
    if (obs_d[0].size() != ob + 1) begin
      errors++;
      $display("FAIL single_resp_count: %0d, need 1", obs_d[0].size() - ob);
    end else begin
      checks++;
      if (obs_c[0][ob] !== t + 5 || obs_d[0][ob] !== 32'h11223344) begin
        errors++;
        $display("FAIL single_resp: T+%0d data %h, need T+5 data 11223344", obs_c[0][ob] - t, obs_d[0][ob]);
      end
    end
  endtask
  task automatic test_back_to_back();
    int t, b, ob, v;
    b = acc_c[1].size();
    ob = obs_d[1].size();
    t = cyc;
    for (int i = 0; i < 4; i++) rd_req(1, 23'(i));
    wait_obs(1, ob + 4);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (acc_c[1].size() != b + 4 || obs_d[1].size() != ob + 4) begin
      errors++;
      $display("FAIL b2b_counts: %0d accepts %0d responses, need 4/4", acc_c[1].size() - b, obs_d[1].size() - ob);
    end else begin
      checks++;
      if (acc_c[1][b] !== t + 1) begin
        errors++;
        $display("FAIL b2b_first_acc: T+%0d, need T+1", acc_c[1][b] - t);
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_c[1][b+i] - acc_c[1][b+i-1] !== 2) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: %0d cycles, need 2", i, acc_c[1][b+i] - acc_c[1][b+i-1]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_d[1][ob+i] !== exp_d[1][b+i]) begin
          errors++;
          $display("FAIL b2b_data[%0d]: %h, need %h", i, obs_d[1][ob+i], exp_d[1][b+i]);
        end
      end
      v = obs_c[1][ob+3];
      checks++;
      if (busy_log[1][v % 4096] !== 1'b1 || busy_log[1][(v + 1) % 4096] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy: busy %0b at last valid, %0b after, need 1 then 0",
                 busy_log[1][v % 4096], busy_log[1][(v + 1) % 4096]);
      end
    end
  endtask
  task automatic test_stall();
    int b, ob;
    b = acc_c[2].size();
    ob = obs_d[2].size();
    for (int i = 0; i < 6; i++) rd_req(2, 23'(8 + i));
    wait_obs(2, ob + 6);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (acc_c[2].size() != b + 6 || obs_d[2].size() != ob + 6) begin
      errors++;
      $display("FAIL stall_counts: %0d accepts %0d responses, need 6/6", acc_c[2].size() - b, obs_d[2].size() - ob);
    end else begin
      checks++;
      if (acc_c[2][b+2] - acc_c[2][b+1] <= 2) begin
        errors++;
        $display("FAIL stall_third: spacing %0d cycles, need more than 2", acc_c[2][b+2] - acc_c[2][b+1]);
      end
      for (int i = 2; i < 6; i++) begin
        checks++;
        if (obs_c[2][ob+i-2] > acc_c[2][b+i]) begin
          errors++;
          $display("FAIL stall_outstanding[%0d]: accept at %0d before response %0d at %0d",
                   i, acc_c[2][b+i], i - 2, obs_c[2][ob+i-2]);
        end
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_d[2][ob+i] !== exp_d[2][b+i]) begin
          errors++;
          $display("FAIL stall_data[%0d]: %h, need %h", i, obs_d[2][ob+i], exp_d[2][b+i]);
        end
      end
    end
  endtask
  task automatic test_abort();
    int b, ob, rb;
    b = acc_c[0].size();
    ob = obs_d[0].size();
    rb = rdn_c[0].size();
    rd[0] = 1'b1;
    ad[0] = 23'h000020;
    @(posedge clk);
    #1;
    rd[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (acc_c[0].size() != b || rdn_c[0].size() != rb || obs_d[0].size() != ob) begin
      errors++;
      $display("FAIL abort: accepts %0d rden %0d responses %0d, need 0/0/0",
               acc_c[0].size() - b, rdn_c[0].size() - rb, obs_d[0].size() - ob);
    end
    checks++;
    if (bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: %0b, need 0", bsy[0]);
    end
  endtask
  task automatic test_addr_check();
    int t, b, ob, rb;
    b = acc_c[0].size();
    ob = obs_d[0].size();
    rb = rdn_c[0].size();
    t = cyc;
    rd_req(0, 23'h100000);
    repeat (8) @(posedge clk);
    #1;
`ifdef FLASH_RESP_ADDR_CHECK_EN
    checks++;
    if (rdn_c[0].size() != rb) begin
      errors++;
      $display("FAIL addr_rden: %0d pulses, need 0", rdn_c[0].size() - rb);
    end
`else
    checks++;
    if (rdn_c[0].size() != rb + 1) begin
      errors++;
      $display("FAIL addr_rden: %0d pulses, need 1", rdn_c[0].size() - rb);
    end else begin
      checks++;
      if (rdn_a[0][rb] !== 23'h100000) begin
        errors++;
        $display("FAIL addr_rom_address: %h, need 100000", rdn_a[0][rb]);
      end
    end
`endif
    checks++;
    if (obs_d[0].size() != ob + 1 || acc_c[0].size() != b + 1) begin
      errors++;
      $display("FAIL addr_resp_count: %0d, need 1", obs_d[0].size() - ob);
    end else begin
      checks++;
      if (obs_c[0][ob] !== t + 5 || obs_d[0][ob] !== exp_d[0][b]) begin
        errors++;
        $display("FAIL addr_resp: T+%0d data %h, need T+5 data %h", obs_c[0][ob] - t, obs_d[0][ob], exp_d[0][b]);
      end
    end
  endtask
  task automatic test_reset_mid();
    int ob;
    ob = obs_d[2].size();
    rd_req(2, 23'h000005);
    rd_req(2, 23'h000006);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rv[2], rdat[2], rdn[2], ra[2], bsy[2], wr[2]} !== {1'b0, 32'h0, 1'b0, 23'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_vals: rv=%0b rd=%h rden=%0b ra=%h busy=%0b wr=%0b, need 0/0/0/0/0/1",
               rv[2], rdat[2], rdn[2], ra[2], bsy[2], wr[2]);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (obs_d[2].size() != ob) begin
      errors++;
      $display("FAIL mid_reset_resp: %0d responses after reset, need 0", obs_d[2].size() - ob);
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0;
      ad[k] = '0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_abort();
    test_addr_check();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
